// File: rtl/fdiv_iter.sv
// Iterative IEEE-754 single-precision divider, y = x1 / x2, restoring shift-subtract
// on 24-bit mantissas with round-to-nearest-even and a fixed, operand-independent latency.
//
// state   | meaning
// IDLE    | waiting for a request; in_ready high
// DIV     | resolving QBITS_PER_CYCLE quotient bits per cycle for N cycles
// ROUND   | rounding, range checks and special operands into the result registers
// DONE    | response valid, held until out_ready
module fdiv_iter #(
    parameter int QBITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        overflow,
    output logic        underflow,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int N  = 25 / QBITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_ROUND,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [23:0]        m2_q, m2_d;
    logic [25:0]        rem_q, rem_d;
    logic [24:0]        quo_q, quo_d;
    logic               z1_q, z1_d;
    logic               z2_q, z2_d;
    logic [31:0]        y_q, y_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    logic [23:0]        m1_c, m2_c;
    logic signed [9:0]  e_c;
    logic [25:0]        rem_it;
    logic [24:0]        quo_it;
    logic               guard, lsb, sticky, rnd_up;
    logic [24:0]        mant_r;
    logic signed [9:0]  exp_r;
    logic [22:0]        frac_r;
    logic [31:0]        y_r;
    logic               ovf_r, unf_r;

    always_comb begin
        m1_c = {1'b1, x1[22:0]};
        m2_c = {1'b1, x2[22:0]};
        e_c  = $signed({2'b00, x1[30:23]}) - $signed({2'b00, x2[30:23]}) + 10'sd127;
    end

    always_comb begin
        rem_it = rem_q;
        quo_it = quo_q;
        for (int i = 0; i < QBITS_PER_CYCLE; i++) begin
            if (rem_it >= {2'b00, m2_q}) begin
                rem_it = rem_it - {2'b00, m2_q};
                quo_it = {quo_it[23:0], 1'b1};
            end else begin
                quo_it = {quo_it[23:0], 1'b0};
            end
            rem_it = {rem_it[24:0], 1'b0};
        end
    end

    // A round-up carry out of the 24-bit mantissa leaves 1.000 with the exponent bumped.
    always_comb begin
        guard  = quo_q[0];
        lsb    = quo_q[1];
        sticky = |rem_q;
        rnd_up = guard & (sticky | lsb);
        mant_r = {1'b0, quo_q[24:1]} + {24'd0, rnd_up};
        exp_r  = exp_q + (mant_r[24] ? 10'sd1 : 10'sd0);
        frac_r = mant_r[24] ? 23'd0 : mant_r[22:0];

        y_r   = {sign_q, exp_r[7:0], frac_r};
        ovf_r = 1'b0;
        unf_r = 1'b0;
        if (z1_q && z2_q) begin
            y_r   = {sign_q, 8'hFF, 23'h400000};
            ovf_r = 1'b1;
        end else if (z2_q) begin
            y_r   = {sign_q, 8'hFF, 23'h0};
            ovf_r = 1'b1;
        end else if (z1_q) begin
            y_r = {sign_q, 31'h0};
        end else if (exp_r >= 10'sd255) begin
            y_r   = {sign_q, 8'hFF, 23'h0};
            ovf_r = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            y_r   = {sign_q, 31'h0};
            unf_r = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        m2_d    = m2_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        z1_d    = z1_q;
        z2_d    = z2_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d = x1[31] ^ x2[31];
                    m2_d   = m2_c;
                    quo_d  = 25'd0;
                    z1_d   = (x1[30:23] == 8'd0);
                    z2_d   = (x2[30:23] == 8'd0);
                    cnt_d  = CW'(N - 1);
                    // Pre-normalise so the quotient always lands in 1.xxx form.
                    if (m1_c < m2_c) begin
                        rem_d = {1'b0, m1_c, 1'b0};
                        exp_d = e_c - 10'sd1;
                    end else begin
                        rem_d = {2'b00, m1_c};
                        exp_d = e_c;
                    end
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                rem_d = rem_it;
                quo_d = quo_it;
                if (cnt_q == '0) begin
                    state_d = S_ROUND;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ROUND: begin
                y_d     = y_r;
                ovf_d   = ovf_r;
                unf_d   = unf_r;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            m2_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            z1_q    <= 1'b0;
            z2_q    <= 1'b0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            m2_q    <= m2_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            z1_q    <= z1_d;
            z2_q    <= z2_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign y         = y_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// Self-checking bench for fdiv_iter: expected results are queued at request time and
// compared when the response appears, together with latency, backpressure and reset checks.
module tb_fdiv_iter;

    localparam int QB = 1;
    localparam int N  = 25 / QB;

    logic        clk;
    logic        rstn;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y;
    logic        overflow;
    logic        underflow;
    logic        out_valid;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] y;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs[$];

    fdiv_iter #(.QBITS_PER_CYCLE(QB)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .x1        (x1),
        .x2        (x2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .overflow  (overflow),
        .underflow (underflow),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic sb_push(input logic [31:0] ey, input logic eo, input logic eu);
        exp_t e;
        e.y   = ey;
        e.ovf = eo;
        e.unf = eu;
        sb.push_back(e);
    endtask

    // Leaves the caller #1 after the accept edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 100) chk("send_timeout", 32'(in_ready), 32'd1);
        x1       = a;
        x2       = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the accept edge; out_valid is due in cycle N+2.
    task automatic wait_out(input string tag);
        int cyc;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(N + 2));
    endtask

    task automatic cmp_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_y"}, y, e.y);
            chk({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
            chk({tag, "_unf"}, 32'(underflow), 32'(e.unf));
        end
    endtask

    task automatic recv(input string tag);
        wait_out(tag);
        cmp_out(tag);
        @(posedge clk);
        #1;
        chk({tag, "_idle_after"}, 32'(in_ready), 32'd1);
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ey,
                           input logic eo, input logic eu);
        vec_t v;
        v.a   = a;
        v.b   = b;
        v.y   = ey;
        v.ovf = eo;
        v.unf = eu;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] y_hold;
        int          seen;

        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x1        = '0;
        x2        = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", y, 32'h0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        add_vec(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
        add_vec(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0);
        add_vec(32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1'b0);
        add_vec(32'h7F000000, 32'h00800000, 32'h7F800000, 1'b1, 1'b0);
        add_vec(32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b1);
        add_vec(32'h3FFFFFFF, 32'h3F800000, 32'h3FFFFFFF, 1'b0, 1'b0);
        add_vec(32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0);
        add_vec(32'h00000000, 32'hC0000000, 32'h80000000, 1'b0, 1'b0);
        add_vec(32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0);
        add_vec(32'h00400000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0);
        add_vec(32'h3F800000, 32'h00000001, 32'h7F800000, 1'b1, 1'b0);
        add_vec(32'h40000000, 32'h40400000, 32'h3F2AAAAB, 1'b0, 1'b0);
        add_vec(32'h41200000, 32'h40800000, 32'h40200000, 1'b0, 1'b0);
        add_vec(32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b1, 1'b0);
        add_vec(32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 1'b0);
        add_vec(32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            sb_push(vecs[i].y, vecs[i].ovf, vecs[i].unf);
            send(vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_busy", i), 32'(in_ready), 32'd0);
            recv($sformatf("v%0d", i));
        end

        // Backpressure in DONE with a competing request held on the input.
        out_ready = 1'b0;
        sb_push(32'h40400000, 1'b0, 1'b0);
        send(32'h40C00000, 32'h40000000);
        wait_out("bp");
        y_hold   = y;
        x1       = 32'h3F800000;
        x2       = 32'h40400000;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_y_stable", y, y_hold);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        cmp_out("bp");
        out_ready = 1'b1;
        sb_push(32'h3EAAAAAB, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        chk("b2b_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_accepted", 32'(in_ready), 32'd0);
        recv("b2b");

        // Reset ten cycles into DIV discards the operation.
        send(32'h40C00000, 32'h40000000);
        repeat (10) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_y", y, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        seen = 0;
        repeat (N + 10) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        chk("mid_rst_no_resp", 32'(seen), 32'd0);
        sb_push(32'h40400000, 1'b0, 1'b0);
        send(32'h40C00000, 32'h40000000);
        recv("post_rst");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
